pc_redirect: RTL and testbench

//  Fetch-stage PC register and next-PC selector. Consumes the decode-stage branch-taken bit from
//  the branch comparator, plus jump/jr decode info, and produces the fetch PC driving inst SRAM.

---
 rtl/pc_redirect.sv | 72 +++++++
 tb/tb_pc_redirect.sv | 104 ++++++++++
 2 files changed

// File: rtl/pc_redirect.sv
// pc_redirect: fetch PC register with next-PC selection and a buffered redirect held across fetch stalls
module pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] EXC_PC   = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flush_exc,
  input  logic [31:0] exc_pc_i,
  input  logic        branchD,
  input  logic        takenD,
  input  logic        jumpD,
  input  logic        jrD,
  input  logic [31:0] pc_plus4D,
  input  logic [15:0] imm16D,
  input  logic [25:0] instr_indexD,
  input  logic [31:0] rs_valueD,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  output logic        adelF,
  output logic        pend_valid
);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state, state_n;
  logic [31:0] pend_target, pend_target_n, pc_n, br_target, j_target, target;
  logic redir_req;
  assign br_target = pc_plus4D + {{14{imm16D[15]}}, imm16D, 2'b00};
  assign j_target = {pc_plus4D[31:28], instr_indexD, 2'b00};
  assign target = jrD ? rs_valueD : jumpD ? j_target : br_target;
  assign redir_req = !stallD & ((branchD & takenD) | jumpD | jrD);
  assign pc_plus4F = pcF + 32'd4;
  assign inst_sram_en = !rst;
  assign inst_sram_addr = pcF;
  assign adelF = |pcF[1:0];
  assign pend_valid = state == PEND;
  always_comb begin
    state_n = state;
    pend_target_n = pend_target;
    pc_n = pc_plus4F;
    if (flush_exc) begin
      pc_n = exc_pc_i != 32'd0 ? exc_pc_i : EXC_PC;
      state_n = IDLE;
    end else if (stallF) begin
      pc_n = pcF;
      if (redir_req) begin
        state_n = PEND;
        pend_target_n = target;
      end
    end else if (redir_req) begin
      pc_n = target;
      state_n = IDLE;
    end else if (state == PEND) begin
      pc_n = pend_target;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF <= RESET_PC;
      state <= IDLE;
      pend_target <= '0;
    end else begin
      pcF <= pc_n;
      state <= state_n;
      pend_target <= pend_target_n;
    end
  end
endmodule

// File: tb/tb_pc_redirect.sv
// tb_pc_redirect: directed and randomized checks of pc_redirect against a rule-level model
module tb_pc_redirect;
  logic clk = 0, rst, stallF, stallD, flush_exc, branchD, takenD, jumpD, jrD;
  logic [31:0] exc_pc_i, pc_plus4D, rs_valueD;
  logic [15:0] imm16D;
  logic [25:0] instr_indexD;
  logic [31:0] pcF, pc_plus4F, inst_sram_addr;
  logic inst_sram_en, adelF, pend_valid;
  int checks = 0, failures = 0;
  logic [31:0] m_pc, m_pt;
  logic m_pv;
  always #5 clk = ~clk;
  pc_redirect dut (.clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flush_exc(flush_exc),
    .exc_pc_i(exc_pc_i), .branchD(branchD), .takenD(takenD), .jumpD(jumpD), .jrD(jrD),
    .pc_plus4D(pc_plus4D), .imm16D(imm16D), .instr_indexD(instr_indexD), .rs_valueD(rs_valueD),
    .pcF(pcF), .pc_plus4F(pc_plus4F), .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .adelF(adelF), .pend_valid(pend_valid));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {rst, stallF, stallD, flush_exc, branchD, takenD, jumpD, jrD} = '0;
    exc_pc_i = 0; pc_plus4D = 0; imm16D = 0; instr_indexD = 0; rs_valueD = 0;
  endtask
  task automatic tick();
    logic [31:0] tgt;
    logic req;
    tgt = jrD ? rs_valueD
        : jumpD ? ((pc_plus4D & 32'hF000_0000) | (32'(instr_indexD) << 2))
        : pc_plus4D + 32'($signed(imm16D) * 4);
    req = !stallD && (jrD || jumpD || (branchD && takenD));
    if (rst) begin m_pc = 32'hBFC0_0000; m_pv = 0; m_pt = 0; end
    else if (flush_exc) begin m_pc = (exc_pc_i != 0) ? exc_pc_i : 32'hBFC0_0380; m_pv = 0; end
    else if (stallF) begin if (req) begin m_pv = 1; m_pt = tgt; end end
    else if (req) begin m_pc = tgt; m_pv = 0; end
    else if (m_pv) begin m_pc = m_pt; m_pv = 0; end
    else m_pc = m_pc + 4;
    @(posedge clk);
    @(negedge clk);
    check("pcF", pcF, m_pc);
    check("pc_plus4F", pc_plus4F, m_pc + 4);
    check("addr", inst_sram_addr, m_pc);
    check("en", 32'(inst_sram_en), 32'(!rst));
    check("adelF", 32'(adelF), 32'(m_pc[1:0] != 0));
    check("pend_valid", 32'(pend_valid), 32'(m_pv));
  endtask
  initial begin
    idle();
    m_pc = 0; m_pv = 0; m_pt = 0;
    @(negedge clk);
    rst = 1; tick(); tick();
    check("t1_en_rst", 32'(inst_sram_en), 0);
    rst = 0; tick();
    check("t1_pc1", pcF, 32'hBFC0_0004);
    tick();
    check("t1_pc2", pcF, 32'hBFC0_0008);
    pc_plus4D = 32'hBFC0_0010; imm16D = 16'hFFFE; branchD = 1; takenD = 1; tick();
    check("t2_taken", pcF, 32'hBFC0_0008);
    takenD = 0; tick();
    check("t2_not_taken", pcF, 32'hBFC0_000C);
    idle(); jrD = 1; jumpD = 1; rs_valueD = 32'h8000_0100; instr_indexD = 26'h123; tick();
    check("t3_jr_wins", pcF, 32'h8000_0100);
    idle(); stallF = 1; branchD = 1; takenD = 1; pc_plus4D = 32'h0000_0FFC; imm16D = 16'h0001; tick();
    check("t4_held", pcF, 32'h8000_0100);
    check("t4_pend", 32'(pend_valid), 1);
    branchD = 0; takenD = 0; tick(); tick();
    stallF = 0; tick();
    check("t4_redir", pcF, 32'h0000_1000);
    check("t4_pend_clr", 32'(pend_valid), 0);
    stallF = 1; jrD = 1; rs_valueD = 32'h1234_5678; tick();
    jrD = 0; flush_exc = 1; exc_pc_i = 0; tick();
    check("t5_exc", pcF, 32'hBFC0_0380);
    check("t5_pend_clr", 32'(pend_valid), 0);
    idle(); stallD = 1; branchD = 1; takenD = 1; pc_plus4D = 32'h0; tick();
    check("t6_stallD", pcF, 32'hBFC0_0384);
    idle(); jrD = 1; rs_valueD = 32'hFFFF_FFFC; tick();
    idle(); tick();
    check("t6_wrap", pcF, 32'h0);
    jrD = 1; rs_valueD = 32'h0000_0102; tick();
    check("t6_adel", 32'(adelF), 1);
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 49) == 0;
      stallF = $urandom_range(0, 9) < 3;
      stallD = $urandom_range(0, 9) < 2;
      flush_exc = $urandom_range(0, 19) == 0;
      exc_pc_i = $urandom_range(0, 1) ? 32'h0 : $urandom;
      branchD = $urandom_range(0, 1);
      takenD = $urandom_range(0, 1);
      jumpD = $urandom_range(0, 4) == 0;
      jrD = $urandom_range(0, 4) == 0;
      pc_plus4D = $urandom;
      imm16D = 16'($urandom);
      instr_indexD = 26'($urandom);
      rs_valueD = $urandom;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
